// File: rtl/jtframe_serjoy.sv
// Scans two arcade panels through a daisy-chained 74HC165-style serial chain.
// Define JTFRAME_SERJOY_DEBOUNCE_EN to require repeated identical scans before outputs change.
module jtframe_serjoy #(
  parameter int DIV       = 4,
  parameter int NBITS     = 24,
  parameter int SCAN_CYC  = 4096,
  parameter int DEB_SCANS = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        joy_sdi,
  output logic        joy_sclk,
  output logic        joy_load_n,
  output logic [15:0] board_joy1,
  output logic [15:0] board_joy2,
  output logic [3:0]  board_coin,
  output logic [3:0]  board_start,
  output logic        absent,
  output logic        scan_done
);
  localparam int PW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, HIGH, LOW, DONE} state_t;

  state_t           r_state, w_next;
  logic [PW-1:0]    r_period;
  logic [7:0]       r_div;
  logic [BW-1:0]    r_bit;
  logic [NBITS-1:0] r_raw;
  logic [23:0]      w_map;
  logic             w_wrap, w_divLast, w_lastBit, w_absent, w_load;

  assign w_wrap    = (r_period == PW'(SCAN_CYC - 1));
  assign w_divLast = (r_div == 8'(DIV - 1));
  assign w_lastBit = (r_bit == BW'(NBITS - 1));
  assign w_absent  = &r_raw;

  always_ff @(posedge clk) begin
    if (rst)         r_period <= '0;
    else if (w_wrap) r_period <= '0;
    else             r_period <= r_period + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A wrap that arrives while a scan is still running is simply lost.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_wrap && enable) w_next = LOAD;
      LOAD:    if (w_divLast) w_next = SETTLE;
      SETTLE:  if (w_divLast) w_next = (NBITS == 1) ? DONE : HIGH;
      HIGH:    if (w_divLast) w_next = LOW;
      LOW:     if (w_divLast) w_next = w_lastBit ? DONE : HIGH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    joy_load_n = (r_state != LOAD);
    joy_sclk   = (r_state == HIGH);
    scan_done  = (r_state == DONE);
  end

  // Bits are taken at the end of SETTLE/LOW, when the chain output has had a full half-period to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_bit <= '0;
      r_raw <= '0;
    end else begin
      if (r_state == IDLE || r_state == DONE || w_divLast) r_div <= '0;
      else                                                 r_div <= r_div + 8'd1;
      if (r_state == IDLE) r_bit <= '0;
      if (w_divLast && (r_state == SETTLE || r_state == LOW)) begin
        r_raw[r_bit] <= ~joy_sdi;
        r_bit        <= r_bit + BW'(1);
      end
    end
  end

  always_comb begin
    w_map = '0;
    for (int i = 0; i < NBITS && i < 24; i++) w_map[i] = r_raw[i];
  end

`ifdef JTFRAME_SERJOY_DEBOUNCE_EN
  logic [NBITS-1:0] r_prev;
  logic [3:0]       r_match, w_matchNext;

  always_comb begin
    w_matchNext = 4'd0;
    if (r_raw == r_prev) w_matchNext = (r_match == 4'd15) ? 4'd15 : r_match + 4'd1;
  end

  assign w_load = (w_matchNext >= 4'(DEB_SCANS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_match <= '0;
    end else if (r_state == DONE) begin
      r_match <= w_matchNext;
      if (r_raw != r_prev) r_prev <= r_raw;
    end
  end
`else
  assign w_load = 1'b1;
`endif

  // A chain reading all zeros is treated as missing and blanks every output at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      board_joy1  <= '0;
      board_joy2  <= '0;
      board_coin  <= '0;
      board_start <= '0;
      absent      <= 1'b0;
    end else if (r_state == DONE) begin
      absent <= w_absent;
      if (w_absent) begin
        board_joy1  <= '0;
        board_joy2  <= '0;
        board_coin  <= '0;
        board_start <= '0;
      end else if (w_load) begin
        board_joy1  <= {6'd0, w_map[9:0]};
        board_joy2  <= {6'd0, w_map[21:12]};
        board_start <= {2'b00, w_map[22], w_map[10]};
        board_coin  <= {2'b00, w_map[23], w_map[11]};
      end
    end
  end

endmodule

// File: tb/tb_jtframe_serjoy.sv
// Bench for jtframe_serjoy: a behavioural 24-bit 74HC165 chain feeds the DUT and every
// completed scan is compared against an expectation queued when its pattern was applied.
module tb_jtframe_serjoy;
  localparam int DIV       = 2;
  localparam int NBITS     = 24;
  localparam int SCAN_CYC  = 256;
  localparam int DEB_SCANS = 2;
  localparam int SCAN_LEN  = 2*DIV + (NBITS-1)*2*DIV + 1;
  localparam int BUDGET    = 1000;

  typedef struct packed {
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic [3:0]  coin;
    logic [3:0]  start;
    logic        absent;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        joySdi;
  logic        joySclk, joyLoadN, absent, scanDone;
  logic [15:0] boardJoy1, boardJoy2;
  logic [3:0]  boardCoin, boardStart;

  logic [23:0] chainPattern = 24'hFFFFFF;
  logic [23:0] chainReg     = 24'hFFFFFF;
  logic        sclkSeen     = 1'b0;

  int      checkCount = 0;
  int      errorCount = 0;
  int      doneCount  = 0;
  expect_t expQueue[$];
  expect_t lastExp;
  expect_t popped;

  bit prevLoad = 1'b1, prevSclk = 1'b0, measuring = 1'b0, pendingCompare = 1'b0;
  int scanLen, loadCycles, sclkPulses, highCycles;

  int  waitCount, pulseCount, loadActivity;
  bit  sclkPrevMain;

  jtframe_serjoy #(.DIV(DIV), .NBITS(NBITS), .SCAN_CYC(SCAN_CYC), .DEB_SCANS(DEB_SCANS)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .joy_sdi    (joySdi),
    .joy_sclk   (joySclk),
    .joy_load_n (joyLoadN),
    .board_joy1 (boardJoy1),
    .board_joy2 (boardJoy2),
    .board_coin (boardCoin),
    .board_start(boardStart),
    .absent     (absent),
    .scan_done  (scanDone)
  );

  always #5 clk = ~clk;

  // Chain model: parallel load while load_n is low, shift one place per rising shift clock.
  always @(posedge clk) begin
    if (!joyLoadN)                chainReg <= chainPattern;
    else if (joySclk && !sclkSeen) chainReg <= {1'b1, chainReg[23:1]};
    sclkSeen <= joySclk;
  end
  assign joySdi = chainReg[0];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic expect_t mkExp(input logic [15:0] j1, input logic [15:0] j2,
                                    input logic [3:0] c, input logic [3:0] s, input logic a);
    expect_t e;
    e.joy1 = j1; e.joy2 = j2; e.coin = c; e.start = s; e.absent = a;
    return e;
  endfunction

  // Measures each scan's waveform and pops the scoreboard the cycle after scan_done.
  always @(negedge clk) begin
    if (rst) begin
      measuring      = 1'b0;
      pendingCompare = 1'b0;
    end else begin
      if (!joyLoadN && prevLoad) begin
        measuring = 1'b1; scanLen = 0; loadCycles = 0; sclkPulses = 0; highCycles = 0;
      end
      if (measuring) begin
        scanLen++;
        if (!joyLoadN) loadCycles++;
        if (joySclk) highCycles++;
        if (joySclk && !prevSclk) sclkPulses++;
      end
      if (pendingCompare) begin
        pendingCompare = 1'b0;
        if (expQueue.size() == 0) checkOutput("scoreboardUnderflow", expQueue.size(), 1);
        else begin
          popped = expQueue.pop_front();
          checkOutput("boardJoy1",  boardJoy1,  popped.joy1);
          checkOutput("boardJoy2",  boardJoy2,  popped.joy2);
          checkOutput("boardCoin",  boardCoin,  popped.coin);
          checkOutput("boardStart", boardStart, popped.start);
          checkOutput("absent",     absent,     popped.absent);
        end
      end
      if (scanDone) begin
        checkOutput("scanLength", scanLen,    SCAN_LEN);
        checkOutput("loadCycles", loadCycles, DIV);
        checkOutput("sclkPulses", sclkPulses, NBITS-1);
        checkOutput("sclkHigh",   highCycles, (NBITS-1)*DIV);
        measuring      = 1'b0;
        pendingCompare = 1'b1;
        doneCount++;
      end
    end
    prevLoad = joyLoadN;
    prevSclk = joySclk;
  end

  task automatic applyScan(input logic [23:0] pattern, input expect_t e, input bit dropEnable);
    int startDone, n;
    chainPattern = pattern;
    expQueue.push_back(e);
    lastExp   = e;
    startDone = doneCount;
    if (dropEnable) begin
      n = 0;
      while (joyLoadN && n < BUDGET) begin @(negedge clk); n++; end
      checkOutput("loadBeforeDrop", joyLoadN, 0);
      enable = 1'b0;
    end
    n = 0;
    while (doneCount == startDone && n < BUDGET) begin @(posedge clk); n++; end
    checkOutput("scanCompleted", doneCount - startDone, 1);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // With debounce a new pattern first yields one holding scan before it is accepted.
  task automatic applyStimulus(input logic [23:0] pattern, input expect_t e, input bit dropEnable);
`ifdef JTFRAME_SERJOY_DEBOUNCE_EN
    expect_t h;
    h = e.absent ? mkExp(16'h0, 16'h0, 4'h0, 4'h0, 1'b1) : lastExp;
    h.absent = e.absent;
    applyScan(pattern, h, 1'b0);
`endif
    applyScan(pattern, e, dropEnable);
  endtask

  initial begin
    lastExp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstSclk",  joySclk,    0);
    checkOutput("rstLoadN", joyLoadN,   1);
    checkOutput("rstJoy1",  boardJoy1,  0);
    checkOutput("rstJoy2",  boardJoy2,  0);
    checkOutput("rstCoin",  boardCoin,  0);
    checkOutput("rstStart", boardStart, 0);
    checkOutput("rstAbsent", absent,    0);
    checkOutput("rstDone",  scanDone,   0);
    rst    = 1'b0;
    enable = 1'b1;

    applyStimulus(~24'h800018, mkExp(16'h0018, 16'h0000, 4'b0010, 4'b0000, 1'b0), 1'b0);
    applyStimulus( 24'hFFFFFF, mkExp(16'h0000, 16'h0000, 4'b0000, 4'b0000, 1'b0), 1'b0);
    applyStimulus( 24'h000000, mkExp(16'h0000, 16'h0000, 4'b0000, 4'b0000, 1'b1), 1'b0);
    applyStimulus(~24'h800000, mkExp(16'h0000, 16'h0000, 4'b0010, 4'b0000, 1'b0), 1'b0);
    applyStimulus(~24'h000001, mkExp(16'h0001, 16'h0000, 4'b0000, 4'b0000, 1'b0), 1'b0);
    applyStimulus(~24'h400400, mkExp(16'h0000, 16'h0000, 4'b0000, 4'b0011, 1'b0), 1'b0);
    applyStimulus(~24'h3FF000, mkExp(16'h0000, 16'h03FF, 4'b0000, 4'b0000, 1'b0), 1'b0);
    applyStimulus(~24'h000A05, mkExp(16'h0205, 16'h0000, 4'b0001, 4'b0000, 1'b0), 1'b0);

    enable       = 1'b0;
    chainPattern = 24'h000000;
    loadActivity = 0;
    for (int i = 0; i < 2*SCAN_CYC + 50; i++) begin
      @(negedge clk);
      if (!joyLoadN) loadActivity++;
    end
    checkOutput("disabledLoad",  loadActivity, 0);
    checkOutput("holdJoy1",      boardJoy1,    lastExp.joy1);
    checkOutput("holdCoin",      boardCoin,    lastExp.coin);
    checkOutput("holdAbsent",    absent,       lastExp.absent);
    enable = 1'b1;

    applyStimulus(~24'h800018, mkExp(16'h0018, 16'h0000, 4'b0010, 4'b0000, 1'b0), 1'b1);

    chainPattern = 24'hFFFFFF;
    waitCount = 0;
    while (joyLoadN && waitCount < BUDGET) begin @(negedge clk); waitCount++; end
    pulseCount   = 0;
    sclkPrevMain = 1'b0;
    waitCount    = 0;
    while (pulseCount < 10 && waitCount < BUDGET) begin
      @(negedge clk);
      waitCount++;
      if (joySclk && !sclkPrevMain) pulseCount++;
      sclkPrevMain = joySclk;
    end
    checkOutput("resetPoint", pulseCount, 10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortSclk",  joySclk,   0);
    checkOutput("abortLoadN", joyLoadN,  1);
    checkOutput("abortJoy1",  boardJoy1, 0);
    checkOutput("abortCoin",  boardCoin, 0);
    rst     = 1'b0;
    lastExp = '0;
    waitCount = 0;
    while (joyLoadN && waitCount < BUDGET) begin @(negedge clk); waitCount++; end
    checkOutput("restartDelay", waitCount, SCAN_CYC);
    applyScan(24'hFFFFFF, mkExp(16'h0000, 16'h0000, 4'b0000, 4'b0000, 1'b0), 1'b0);

`ifdef JTFRAME_SERJOY_DEBOUNCE_EN
    applyScan(~24'h000400, mkExp(16'h0, 16'h0, 4'h0, 4'b0000, 1'b0), 1'b0);
    applyScan( 24'hFFFFFF, mkExp(16'h0, 16'h0, 4'h0, 4'b0000, 1'b0), 1'b0);
    applyScan(~24'h000400, mkExp(16'h0, 16'h0, 4'h0, 4'b0000, 1'b0), 1'b0);
    applyScan(~24'h000400, mkExp(16'h0, 16'h0, 4'h0, 4'b0001, 1'b0), 1'b0);
    applyScan( 24'hFFFFFF, mkExp(16'h0, 16'h0, 4'h0, 4'b0001, 1'b0), 1'b0);
    applyScan( 24'hFFFFFF, mkExp(16'h0, 16'h0, 4'h0, 4'b0000, 1'b0), 1'b0);
`endif

    checkOutput("queueDrained", expQueue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
